// File: rtl/relu_max_pool.sv
// relu_max_pool: ReLU followed by 2x2 stride-2 max pooling over a row stream.
// An even row is reduced pairwise into a line buffer and merged with the next odd row.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module relu_max_pool #(
    parameter int ARRAY_SIZE   = 6,
    parameter int ARRAY_WIDTH  = 3,
    parameter int WEIGHT_WIDTH = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  valid,
    input  logic [ARRAY_SIZE*`DATA_WIDTH-1:0]     feature_in,
    input  logic [WEIGHT_WIDTH-1:0]               feature_idx,
    input  logic [ARRAY_WIDTH-1:0]                feature_row,
    input  logic                                  image_calc_fin,
    output logic                                  pool_valid,
    output logic [(ARRAY_SIZE/2)*`DATA_WIDTH-1:0] pool_data,
    output logic [WEIGHT_WIDTH-1:0]               pool_idx,
    output logic [ARRAY_WIDTH-1:0]                pool_row,
    output logic                                  pool_fin,
    output logic                                  protocol_err
);

    localparam int DW   = `DATA_WIDTH;
    localparam int HALF = ARRAY_SIZE / 2;

    localparam logic S_EVEN = 1'b0;
    localparam logic S_ODD  = 1'b1;

    // Negative inputs (incl. -0 and negative NaN) clamp to +0.
    function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
        return x[DW-1] ? '0 : x;
    endfunction

    // Operands are already non-negative; ties keep the left operand.
    function automatic logic [DW-1:0] vmax(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        return (b[DW-2:0] > a[DW-2:0]) ? b : a;
    endfunction

    logic                    r_state;
    logic [DW-1:0]           r_buf [HALF];
    logic [WEIGHT_WIDTH-1:0] r_idx;
    logic                    r_pool_valid;
    logic [HALF*DW-1:0]      r_pool_data;
    logic [WEIGHT_WIDTH-1:0] r_pool_idx;
    logic [ARRAY_WIDTH-1:0]  r_pool_row;
    logic                    r_pool_fin;
    logic                    r_err;

    logic [DW-1:0]           w_pair [HALF];
    logic [HALF*DW-1:0]      w_pool;
    logic                    w_odd;
    logic                    w_match;
    logic                    w_emit;
    logic                    w_load;
    logic                    w_err;
    logic                    w_next;

    always_comb begin
        w_pool = '0;
        for (int k = 0; k < HALF; k++) begin
            w_pair[k] = vmax(relu(feature_in[(ARRAY_SIZE-1-2*k)*DW +: DW]),
                             relu(feature_in[(ARRAY_SIZE-2-2*k)*DW +: DW]));
            w_pool[(HALF-1-k)*DW +: DW] = vmax(r_buf[k], w_pair[k]);
        end
    end

    assign w_odd   = feature_row[0];
    assign w_match = (feature_idx == r_idx);
    assign w_emit  = valid && (r_state == S_ODD) && w_odd && w_match;
    assign w_load  = valid && !w_odd;

    always_comb begin
        w_err  = 1'b0;
        w_next = r_state;
        if (valid) begin
            unique case (r_state)
                S_EVEN: begin
                    w_err  = w_odd;
                    w_next = w_odd ? S_EVEN : S_ODD;
                end
                S_ODD: begin
                    w_err  = !(w_odd && w_match);
                    w_next = w_odd ? S_EVEN : S_ODD;
                end
                default: w_next = S_EVEN;
            endcase
        end
        // End of image always realigns to an even row.
        if (image_calc_fin) begin
            w_next = S_EVEN;
            if (r_state == S_ODD && !w_emit)
                w_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_EVEN;
            r_idx        <= '0;
            r_pool_valid <= 1'b0;
            r_pool_data  <= '0;
            r_pool_idx   <= '0;
            r_pool_row   <= '0;
            r_pool_fin   <= 1'b0;
            r_err        <= 1'b0;
            for (int k = 0; k < HALF; k++)
                r_buf[k] <= '0;
        end else begin
            r_state      <= w_next;
            r_pool_valid <= w_emit;
            r_pool_data  <= w_emit ? w_pool : '0;
            r_pool_idx   <= w_emit ? feature_idx : '0;
            r_pool_row   <= w_emit ? (feature_row >> 1) : '0;
            r_pool_fin   <= image_calc_fin;
            r_err        <= r_err | w_err;
            if (w_load) begin
                r_idx <= feature_idx;
                for (int k = 0; k < HALF; k++)
                    r_buf[k] <= w_pair[k];
            end
        end
    end

    assign pool_valid   = r_pool_valid;
    assign pool_data    = r_pool_data;
    assign pool_idx     = r_pool_idx;
    assign pool_row     = r_pool_row;
    assign pool_fin     = r_pool_fin;
    assign protocol_err = r_err;

endmodule
